// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains FIFO words and sends each as a UART frame (start, data LSB first, optional parity, stop)
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  i_fifo_empty,
  input  logic [DATA_WIDTH-1:0] i_fifo_rdata,
  output logic                  o_fifo_rinc,
  input  logic                  i_par_en,
  input  logic                  i_par_typ,
  output logic                  o_tx_out,
  output logic                  o_busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t                state;
  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] shr_nxt;
  logic                  par_bit;
  logic                  par_en_q;
  logic                  last;
  logic                  take;
  // bit-period end, next shifted word, and whether this edge pops a new word
  always_comb begin
    last    = cnt == CW'(CLKS_PER_BIT - 1);
    shr_nxt = shreg >> 1;
    take    = !i_fifo_empty && (state == IDLE || (state == STOP && last));
  end
  // frame sequencer; capturing a word also pulses the read strobe for the following cycle
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      shreg       <= '0;
      par_bit     <= 1'b0;
      par_en_q    <= 1'b0;
      o_tx_out    <= 1'b1;
      o_busy      <= 1'b0;
      o_fifo_rinc <= 1'b0;
    end else if (take) begin
      state       <= START;
      cnt         <= '0;
      shreg       <= i_fifo_rdata;
      par_en_q    <= i_par_en;
      par_bit     <= ^i_fifo_rdata ^ i_par_typ;
      o_tx_out    <= 1'b0;
      o_busy      <= 1'b1;
      o_fifo_rinc <= 1'b1;
    end else begin
      o_fifo_rinc <= 1'b0;
      cnt         <= (state == IDLE || last) ? '0 : cnt + 1'b1;
      if (last) begin
        case (state)
          START: begin
            state    <= DATA;
            idx      <= '0;
            o_tx_out <= shreg[0];
          end
          DATA: begin
            if (idx == IW'(DATA_WIDTH - 1)) begin
              state    <= par_en_q ? PARITY : STOP;
              o_tx_out <= par_en_q ? par_bit : 1'b1;
            end else begin
              idx      <= idx + 1'b1;
              shreg    <= shr_nxt;
              o_tx_out <= shr_nxt[0];
            end
          end
          PARITY: begin
            state    <= STOP;
            o_tx_out <= 1'b1;
          end
          STOP: begin
            state    <= IDLE;
            o_tx_out <= 1'b1;
            o_busy   <= 1'b0;
          end
          default: begin
            state    <= IDLE;
            o_tx_out <= 1'b1;
            o_busy   <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule
